// File: rtl/vedic_mac_pkg.sv
// Shared definitions for the Vedic multiply-accumulate pipeline.
//   - legal operand width / guard ranges and the accumulator width function
//   - pipeline stage indices and latency of the multiplier
//   - overflow handling mode and the sideband struct carried through the pipe
package vedic_mac_pkg;

  localparam int W_MIN     = 8;
  localparam int W_MAX     = 32;
  localparam int GUARD_MAX = 32;

  // Multiplier stages: partial products, first add, second add
  localparam int LAT     = 3;
  localparam int ST_PP   = 1;
  localparam int ST_ADD1 = 2;
  localparam int ST_ADD2 = 3;

  typedef enum logic {
    OVF_WRAP = 1'b0,
    OVF_SAT  = 1'b1
  } ovf_mode_e;

  typedef struct packed {
    logic first;
    logic last;
  } side_t;

  function automatic int acc_width(input int w, input int guard);
    return 2 * w + guard;
  endfunction

  function automatic bit w_legal(input int w);
    return (w >= W_MIN) && (w <= W_MAX) && ((w & (w - 1)) == 0);
  endfunction

endpackage

// File: rtl/vedic_mac_pipe_if.sv
// Streaming bus of the MAC pipeline.
//   master: operand producer / result consumer (drives in_*, out_ready)
//   slave : the MAC block (drives in_ready, out_valid, out_acc, out_ovf)
interface vedic_mac_pipe_if #(
  parameter int W  = 16,
  parameter int AW = 40
);
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          in_first;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_acc;
  logic          out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_first, in_last, out_ready,
    input  in_ready, out_valid, out_acc, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_first, in_last, out_ready,
    output in_ready, out_valid, out_acc, out_ovf
  );
endinterface

// File: rtl/vedic_core.sv
// Combinational Urdhva-Tiryagbhyam multiplier, recursive on width.
//   a, b : W-bit unsigned operands (W power of two, >= 2)
//   p    : 2W-bit product
// A 2x2 core is built from gates; wider cores split each operand into halves,
// form four half-width products and combine the vertical/crosswise terms.
module vedic_core #(
  parameter int W = 8
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] p
);
  localparam int H = W / 2;

  generate
    if (W == 2) begin : g_base
      logic t, u, v, c1;
      assign t  = a[1] & b[0];
      assign u  = a[0] & b[1];
      assign v  = a[1] & b[1];
      assign c1 = t & u;
      assign p  = {v & c1, v ^ c1, t ^ u, a[0] & b[0]};
    end else begin : g_rec
      logic [W-1:0] q0, q1, q2, q3;
      logic [W:0]   mid;
      vedic_core #(.W(H)) u_q0 (.a(a[H-1:0]), .b(b[H-1:0]), .p(q0));
      vedic_core #(.W(H)) u_q1 (.a(a[W-1:H]), .b(b[H-1:0]), .p(q1));
      vedic_core #(.W(H)) u_q2 (.a(a[H-1:0]), .b(b[W-1:H]), .p(q2));
      vedic_core #(.W(H)) u_q3 (.a(a[W-1:H]), .b(b[W-1:H]), .p(q3));
      // crosswise terms land H bits up; vertical terms tile the result
      assign mid = {1'b0, q1} + {1'b0, q2};
      assign p   = {q3, q0} + {{(H-1){1'b0}}, mid, {H{1'b0}}};
    end
  endgenerate
endmodule

// File: rtl/vedic_mult_pipe.sv
// Three-stage pipelined W x W unsigned multiplier with sideband.
//   clk, rst_n        : clock, async active-low reset
//   en                : advance the whole pipe (low = hold every register)
//   in_vld/in_a/in_b  : operand pair entering stage 1
//   in_side           : first/last flags travelling with the operands
//   out_vld/out_prod  : 2W-bit product leaving stage 3
//   out_side          : sideband aligned with out_prod
// Stage 1 registers the four half-width products, stage 2 folds them into a
// low and a high partial sum, stage 3 forms the full product.
module vedic_mult_pipe
  import vedic_mac_pkg::*;
#(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           in_vld,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  input  side_t          in_side,
  output logic           out_vld,
  output logic [2*W-1:0] out_prod,
  output side_t          out_side
);
  localparam int H = W / 2;

  logic [W-1:0] pp0, pp1, pp2, pp3;

  vedic_core #(.W(H)) u_pp0 (.a(in_a[H-1:0]), .b(in_b[H-1:0]), .p(pp0));
  vedic_core #(.W(H)) u_pp1 (.a(in_a[W-1:H]), .b(in_b[H-1:0]), .p(pp1));
  vedic_core #(.W(H)) u_pp2 (.a(in_a[H-1:0]), .b(in_b[W-1:H]), .p(pp2));
  vedic_core #(.W(H)) u_pp3 (.a(in_a[W-1:H]), .b(in_b[W-1:H]), .p(pp3));

  logic  [LAT:ST_PP] vld_pipe;
  side_t [LAT:ST_PP] side_pipe;

  // stage ST_PP
  logic [W-1:0]     q0, q1, q2, q3;
  // stage ST_ADD1: product = {s_hi + s_lo, lo2}; both partial sums fit exactly
  logic [H-1:0]     lo2;
  logic [W-1:0]     s_lo;
  logic [W+H-1:0]   s_hi;
  // stage ST_ADD2
  logic [2*W-1:0]   prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      side_pipe <= '0;
      q0        <= '0;
      q1        <= '0;
      q2        <= '0;
      q3        <= '0;
      lo2       <= '0;
      s_lo      <= '0;
      s_hi      <= '0;
      prod      <= '0;
    end else if (en) begin
      vld_pipe  <= {vld_pipe[LAT-1:ST_PP], in_vld};
      side_pipe <= {side_pipe[LAT-1:ST_PP], in_side};
      q0        <= pp0;
      q1        <= pp1;
      q2        <= pp2;
      q3        <= pp3;
      lo2       <= q0[H-1:0];
      s_lo      <= q1 + W'(q0[W-1:H]);
      s_hi      <= (W+H)'(q2) + {q3, {H{1'b0}}};
      prod      <= {s_hi + (W+H)'(s_lo), lo2};
    end
  end

  assign out_vld  = vld_pipe[ST_ADD2];
  assign out_side = side_pipe[ST_ADD2];
  assign out_prod = prod;
endmodule

// File: rtl/vedic_mac_pipe.sv
// Pipelined unsigned multiply-accumulate on a Vedic multiplier.
//   clk, rst_n : clock, async active-low reset
//   bus        : vedic_mac_pipe_if.slave
//                in_valid/in_ready/in_a/in_b/in_first/in_last  operand stream
//                out_valid/out_ready/out_acc/out_ovf           result stream
// Build option: VEDIC_MAC_SAT_EN defined -> accumulator saturates to all ones
// on overflow for the rest of the run; undefined -> accumulator wraps.
// out_ovf reports overflow in both modes.
// A pending unaccepted result stalls the entire pipe so nothing is dropped.
module vedic_mac_pipe
  import vedic_mac_pkg::*;
#(
  parameter int W     = 16,
  parameter int GUARD = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  vedic_mac_pipe_if.slave bus
);
  localparam int AW = acc_width(W, GUARD);

`ifdef VEDIC_MAC_SAT_EN
  localparam ovf_mode_e MODE = OVF_SAT;
`else
  localparam ovf_mode_e MODE = OVF_WRAP;
`endif

  generate
    if (!w_legal(W) || GUARD < 0 || GUARD > GUARD_MAX || ST_ADD2 != LAT ||
        ST_ADD1 != ST_PP + 1) begin : g_bad_cfg
      $error("vedic_mac_pipe: illegal W/GUARD configuration");
    end
  endgenerate

  logic           stall, en;
  side_t          in_side;
  logic           m_vld;
  logic [2*W-1:0] m_prod;
  side_t          m_side;

  logic [AW-1:0]  acc, acc_nxt, base;
  logic [AW:0]    sum;
  logic           run_ovf, ovf_nxt;
  logic           out_valid, out_ovf;
  logic [AW-1:0]  out_acc;

  assign stall        = out_valid & ~bus.out_ready;
  assign en           = ~stall;
  assign bus.in_ready = en;
  assign in_side      = '{first: bus.in_first, last: bus.in_last};

  // The pipe only captures when en, so in_valid alone marks an accepted pair.
  vedic_mult_pipe #(.W(W)) u_mult (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .in_vld   (bus.in_valid),
    .in_a     (bus.in_a),
    .in_b     (bus.in_b),
    .in_side  (in_side),
    .out_vld  (m_vld),
    .out_prod (m_prod),
    .out_side (m_side)
  );

  // first restarts both the sum and the run's overflow flag
  always_comb begin
    base    = m_side.first ? '0 : acc;
    sum     = {1'b0, base} + (AW+1)'(m_prod);
    ovf_nxt = (m_side.first ? 1'b0 : run_ovf) | sum[AW];
    acc_nxt = sum[AW-1:0];
    if (MODE == OVF_SAT && ovf_nxt) acc_nxt = '1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      run_ovf   <= 1'b0;
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_ovf   <= 1'b0;
    end else if (en) begin
      if (m_vld) begin
        acc     <= acc_nxt;
        run_ovf <= ovf_nxt;
      end
      // en implies any held result is being accepted this cycle
      if (m_vld && m_side.last) begin
        out_valid <= 1'b1;
        out_acc   <= acc_nxt;
        out_ovf   <= ovf_nxt;
      end else if (bus.out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign bus.out_valid = out_valid;
  assign bus.out_acc   = out_acc;
  assign bus.out_ovf   = out_ovf;
endmodule

// File: tb/tb_vedic_mac_pipe.sv
// Self-checking bench for vedic_mac_pipe. Three instances share one stimulus
// stream: W=16/GUARD=8, W=16/GUARD=0 and W=32/GUARD=8. The reference model
// keeps each run's sum with plain wide arithmetic and reduces it to AW bits.
module tb_vedic_mac_pipe;

`ifdef VEDIC_MAC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  localparam int BUDGET = 20000;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        first;
    logic        last;
  } elem_t;

  typedef struct packed {
    logic [2:0][127:0] acc;
    logic [2:0]        ovf;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic        first = 1'b0;
  logic        last = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] a = '0;
  logic [31:0] b = '0;

  int total = 0;
  int bad   = 0;

  elem_t        stim[$];
  res_t         expq[$];
  res_t         gotq[$];
  logic [127:0] m_acc[3];
  logic         m_ovf[3];

  always #5 clk = ~clk;

  vedic_mac_pipe_if #(.W(16), .AW(40)) if16 ();
  vedic_mac_pipe_if #(.W(16), .AW(32)) if0 ();
  vedic_mac_pipe_if #(.W(32), .AW(72)) if32 ();

  assign if16.in_valid = valid;  assign if0.in_valid = valid;  assign if32.in_valid = valid;
  assign if16.in_first = first;  assign if0.in_first = first;  assign if32.in_first = first;
  assign if16.in_last  = last;   assign if0.in_last  = last;   assign if32.in_last  = last;
  assign if16.out_ready = out_ready;
  assign if0.out_ready  = out_ready;
  assign if32.out_ready = out_ready;
  assign if16.in_a = a[15:0];    assign if16.in_b = b[15:0];
  assign if0.in_a  = a[15:0];    assign if0.in_b  = b[15:0];
  assign if32.in_a = a;          assign if32.in_b = b;

  vedic_mac_pipe #(.W(16), .GUARD(8)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));
  vedic_mac_pipe #(.W(16), .GUARD(0)) dut0  (.clk(clk), .rst_n(rst_n), .bus(if0));
  vedic_mac_pipe #(.W(32), .GUARD(8)) dut32 (.clk(clk), .rst_n(rst_n), .bus(if32));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic int aw_of(input int k);
    case (k)
      0:       return 40;
      1:       return 32;
      default: return 72;
    endcase
  endfunction

  function automatic logic [127:0] obs_acc(input int k);
    case (k)
      0:       return 128'(if16.out_acc);
      1:       return 128'(if0.out_acc);
      default: return 128'(if32.out_acc);
    endcase
  endfunction

  function automatic logic obs_ovf(input int k);
    case (k)
      0:       return if16.out_ovf;
      1:       return if0.out_ovf;
      default: return if32.out_ovf;
    endcase
  endfunction

  // One accepted element: product added to the running sum, reduced to AW bits.
  task automatic model_step(input elem_t e);
    res_t         r;
    logic [127:0] p, lim, t, ma, mb;
    r = '0;
    for (int k = 0; k < 3; k++) begin
      ma  = (k == 2) ? 128'(e.a) : 128'(e.a[15:0]);
      mb  = (k == 2) ? 128'(e.b) : 128'(e.b[15:0]);
      p   = ma * mb;
      lim = 128'd1 << aw_of(k);
      if (e.first) begin
        m_acc[k] = '0;
        m_ovf[k] = 1'b0;
      end
      t = m_acc[k] + p;
      if (t >= lim) begin
        m_ovf[k] = 1'b1;
        t = SAT ? lim - 128'd1 : t - lim;
      end
      m_acc[k] = t;
      r.acc[k] = m_acc[k];
      r.ovf[k] = m_ovf[k];
    end
    if (e.last) expq.push_back(r);
  endtask

  // Streams stim[] through all instances. policy 0: out_ready=1,
  // 1: random valid gaps and random out_ready, 2: hold out_ready low for 10
  // cycles once the first result shows up.
  task automatic stream(input int policy);
    int nres = 0;
    foreach (stim[i]) if (stim[i].last) nres++;
    gotq.delete();
    fork
      begin
        int idx = 0;
        int cyc = 0;
        while (idx < stim.size() && cyc < BUDGET) begin
          @(negedge clk); #1; cyc++;
          valid = (policy == 1) ? ($urandom_range(3) != 0) : 1'b1;
          a     = stim[idx].a;
          b     = stim[idx].b;
          first = stim[idx].first;
          last  = stim[idx].last;
          if (valid && if16.in_ready) begin
            model_step(stim[idx]);
            idx++;
          end
        end
        @(negedge clk);
        valid = 1'b0;
        if (idx < stim.size()) chk("drv_timeout", 128'(idx), 128'(stim.size()));
      end
      begin
        int   got = 0;
        int   cyc = 0;
        int   hold = 0;
        logic stalled = 1'b0;
        res_t held = '0;
        res_t r, o;
        while (got < nres && cyc < BUDGET) begin
          @(negedge clk); cyc++;
          if (stalled)
            for (int k = 0; k < 3; k++)
              chk($sformatf("hold_acc%0d", k), obs_acc(k), held.acc[k]);
          if (policy == 1)
            out_ready = 1'($urandom_range(1));
          else if (policy == 2 && if16.out_valid && hold < 10) begin
            out_ready = 1'b0;
            hold++;
          end else
            out_ready = 1'b1;
          if (if16.out_valid)
            chk("valid_match", {126'd0, if0.out_valid, if32.out_valid}, 128'd3);
          stalled = if16.out_valid && !out_ready;
          for (int k = 0; k < 3; k++) begin
            o.acc[k] = obs_acc(k);
            o.ovf[k] = obs_ovf(k);
          end
          held = o;
          if (if16.out_valid && out_ready) begin
            if (expq.size() == 0) chk("extra_result", 128'd0, 128'd1);
            else begin
              r = expq.pop_front();
              for (int k = 0; k < 3; k++) begin
                chk($sformatf("res%0d_acc%0d", got, k), o.acc[k], r.acc[k]);
                chk($sformatf("res%0d_ovf%0d", got, k), 128'(o.ovf[k]), 128'(r.ovf[k]));
              end
            end
            gotq.push_back(o);
            got++;
          end
          if (stalled) begin
            #1;
            chk("in_ready_stall", 128'(if16.in_ready), 128'd0);
          end
        end
        out_ready = 1'b1;
        if (got < nres) chk("mon_timeout", 128'(got), 128'(nres));
      end
    join
    stim.delete();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    elem_t e;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_valid", 128'(if16.out_valid), 128'd0);
    chk("rst_acc", obs_acc(0), 128'd0);
    chk("rst_ovf", 128'(if16.out_ovf), 128'd0);
    chk("rst_in_ready", 128'(if16.in_ready), 128'd1);
    rst_n = 1'b1;

    // single-element run and its latency
    @(negedge clk);
    a = 32'hFFFF; b = 32'hFFFF; first = 1'b1; last = 1'b1; valid = 1'b1;
    @(negedge clk); valid = 1'b0;
    chk("t1_lat1", 128'(if16.out_valid), 128'd0);
    @(negedge clk);
    chk("t1_lat2", 128'(if16.out_valid), 128'd0);
    @(negedge clk);
    chk("t1_lat3", 128'(if16.out_valid), 128'd0);
    @(negedge clk);
    chk("t1_lat4", 128'(if16.out_valid), 128'd1);
    chk("t1_acc16", obs_acc(0), 128'hFFFE0001);
    chk("t1_ovf16", 128'(if16.out_ovf), 128'd0);
    chk("t1_acc32", obs_acc(2), 128'hFFFE0001);
    @(negedge clk);
    chk("t1_drop", 128'(if16.out_valid), 128'd0);

    // two-element run then an independent run
    stim.push_back('{a: 3, b: 5,  first: 1'b1, last: 1'b0});
    stim.push_back('{a: 7, b: 11, first: 1'b0, last: 1'b1});
    stim.push_back('{a: 2, b: 2,  first: 1'b1, last: 1'b1});
    stream(0);
    chk("t2_count", 128'(gotq.size()), 128'd2);
    if (gotq.size() >= 2) begin
      chk("t2_run1", gotq[0].acc[0], 128'd92);
      chk("t2_run2", gotq[1].acc[0], 128'd4);
    end

    // overflow with no guard bits
    stim.push_back('{a: 32'hFFFF, b: 32'hFFFF, first: 1'b1, last: 1'b0});
    stim.push_back('{a: 32'hFFFF, b: 32'hFFFF, first: 1'b0, last: 1'b1});
    stream(0);
    chk("t3_count", 128'(gotq.size()), 128'd1);
    if (gotq.size() >= 1) begin
      chk("t3_acc_g0", gotq[0].acc[1], SAT ? 128'hFFFFFFFF : 128'hFFFC0002);
      chk("t3_ovf_g0", 128'(gotq[0].ovf[1]), 128'd1);
      chk("t3_acc_g8", gotq[0].acc[0], 128'h1FFFC0002);
      chk("t3_ovf_g8", 128'(gotq[0].ovf[0]), 128'd0);
    end

    // five queued runs behind a 10-cycle output stall
    for (int i = 0; i < 5; i++) begin
      e = '{a: 32'(i + 1), b: 32'd3, first: 1'b1, last: 1'b1};
      stim.push_back(e);
    end
    stream(2);
    chk("t4_count", 128'(gotq.size()), 128'd5);
    for (int i = 0; i < 5 && i < gotq.size(); i++)
      chk($sformatf("t4_run%0d", i), gotq[i].acc[0], 128'(3 * (i + 1)));

    // reset while a result is held and two elements are in flight
    out_ready = 1'b0;
    @(negedge clk); a = 9; b = 9; first = 1'b1; last = 1'b1; valid = 1'b1;
    @(negedge clk); a = 5; b = 5; first = 1'b1; last = 1'b0;
    @(negedge clk); a = 6; b = 6; first = 1'b0; last = 1'b1;
    @(negedge clk); valid = 1'b0; first = 1'b0; last = 1'b0;
    repeat (4) @(negedge clk);
    chk("t5_pre_valid", 128'(if16.out_valid), 128'd1);
    chk("t5_pre_acc", obs_acc(0), 128'd81);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 128'(if16.out_valid), 128'd0);
    chk("t5_rst_acc", obs_acc(0), 128'd0);
    chk("t5_rst_ovf", 128'(if16.out_ovf), 128'd0);
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    stim.push_back('{a: 2, b: 2, first: 1'b1, last: 1'b1});
    stream(0);
    chk("t5_count", 128'(gotq.size()), 128'd1);
    if (gotq.size() >= 1) chk("t5_acc", gotq[0].acc[0], 128'd4);

    // random streams with throttled output
    for (int i = 0; i < 1000; i++) begin
      e.a     = $urandom;
      e.b     = $urandom;
      e.first = (i == 0) || ($urandom_range(7) == 0);
      e.last  = (i == 999) || ($urandom_range(7) == 0);
      stim.push_back(e);
    end
    stream(1);
    chk("t6_leftover", 128'(expq.size()), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
